// File: rtl/fsd_core.sv
// fsd_core: multi-channel frequency/period measurement front end.
//   - Per channel a programmable local oscillator (lo_out, period = cycle clocks)
//     and a mixer output mix_out = mix_in ^ lo_out.
//   - Per channel two period meters (mixer input and signal input) that average
//     2^AVG_LOG2 consecutive periods and flag counter saturation.
//   - Level/ack read port returning one latched result at a time.
// Ports:
//   clk24M, rst                  clock, asynchronous active-high reset
//   mix_in, sig_in   [NCH]       asynchronous measurement inputs
//   lo_out, mix_out  [NCH]       oscillator and mixer outputs
//   cfg_we/cfg_ch/cfg_cycle      LO cycle write (restarts the channel phase)
//   rd_req/rd_ch/rd_sel          read request, channel, 0 = raw / 1 = signal
//   rd_ack/rd_data/rd_valid/rd_ovf  read response

// Period meter for one asynchronous input.
// Ports: clk_i, rst_i, din_i (async input), res_o / valid_o / ovf_o (averaged result).
module fsd_meas #(
    parameter int W        = 16,
    parameter int AVG_LOG2 = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         din_i,
    output logic [W-1:0] res_o,
    output logic         valid_o,
    output logic         ovf_o
);
    localparam int SW = W + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam logic [NW-1:0] LAST = NW'((1 << AVG_LOG2) - 1);

    // sync_q[1:0] is the synchroniser, sync_q[2] the history bit for edge detect
    logic [2:0]    sync_q;
    logic          edge_q;
    logic          armed_q;
    logic [W-1:0]  cnt_q;
    logic [SW-1:0] sum_q;
    logic [NW-1:0] n_q;
    logic          sat_q;
    logic [W-1:0]  res_q;
    logic          valid_q;
    logic          ovf_q;

    logic [SW-1:0] sum_d;
    logic          sat_d;

    // The period just ended is the counter value seen alongside the edge pulse.
    assign sum_d = sum_q + SW'(cnt_q);
    assign sat_d = sat_q | (cnt_q == '1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            n_q     <= '0;
            sat_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], din_i};
            edge_q <= sync_q[1] & ~sync_q[2];

            if (edge_q) begin
                cnt_q <= W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + W'(1);
            end

            if (edge_q) begin
                if (!armed_q) begin
                    armed_q <= 1'b1;
                end else if (n_q == LAST) begin
                    res_q   <= sat_d ? '1 : W'(sum_d >> AVG_LOG2);
                    ovf_q   <= sat_d;
                    valid_q <= 1'b1;
                    sum_q   <= '0;
                    n_q     <= '0;
                    sat_q   <= 1'b0;
                end else begin
                    sum_q <= sum_d;
                    n_q   <= n_q + NW'(1);
                    sat_q <= sat_d;
                end
            end
        end
    end

    assign res_o   = res_q;
    assign valid_o = valid_q;
    assign ovf_o   = ovf_q;
endmodule

module fsd_core #(
    parameter int NCH      = 3,
    parameter int LO_W     = 16,
    parameter int RAW_W    = 16,
    parameter int SIG_W    = 24,
    parameter int AVG_LOG2 = 2,
    parameter int LO_RST   = 100
) (
    input  logic             clk24M,
    input  logic             rst,
    input  logic [NCH-1:0]   mix_in,
    input  logic [NCH-1:0]   sig_in,
    output logic [NCH-1:0]   lo_out,
    output logic [NCH-1:0]   mix_out,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [LO_W-1:0]  cfg_cycle,
    input  logic             rd_req,
    input  logic [2:0]       rd_ch,
    input  logic             rd_sel,
    output logic             rd_ack,
    output logic [SIG_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_ovf
);
    logic [LO_W-1:0]  cycle_q [NCH];
    logic [LO_W-1:0]  lo_cnt_q [NCH];
    logic [NCH-1:0]   lo_q;

    logic [RAW_W-1:0] raw_res [NCH];
    logic [NCH-1:0]   raw_valid;
    logic [NCH-1:0]   raw_ovf;
    logic [SIG_W-1:0] sig_res [NCH];
    logic [NCH-1:0]   sig_valid;
    logic [NCH-1:0]   sig_ovf;

    logic             rd_ack_q;
    logic [SIG_W-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             rd_ovf_q;

    logic [SIG_W-1:0] sel_data_d;
    logic             sel_valid_d;
    logic             sel_ovf_d;

    // Local oscillators; cycles below 2 park the channel low.
    always_ff @(posedge clk24M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cycle_q[i]  <= LO_W'(LO_RST);
                lo_cnt_q[i] <= '0;
            end
            lo_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    cycle_q[i]  <= cfg_cycle;
                    lo_cnt_q[i] <= '0;
                    lo_q[i]     <= 1'b0;
                end else if (cycle_q[i] < LO_W'(2)) begin
                    lo_cnt_q[i] <= '0;
                    lo_q[i]     <= 1'b0;
                end else begin
                    if (lo_cnt_q[i] == cycle_q[i] - LO_W'(1)) begin
                        lo_cnt_q[i] <= '0;
                        lo_q[i]     <= 1'b1;
                    end else begin
                        lo_cnt_q[i] <= lo_cnt_q[i] + LO_W'(1);
                        if (lo_cnt_q[i] == (cycle_q[i] >> 1) - LO_W'(1)) begin
                            lo_q[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign lo_out  = lo_q;
    assign mix_out = mix_in ^ lo_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        fsd_meas #(.W(RAW_W), .AVG_LOG2(AVG_LOG2)) u_mix (
            .clk_i   (clk24M),
            .rst_i   (rst),
            .din_i   (mix_in[g]),
            .res_o   (raw_res[g]),
            .valid_o (raw_valid[g]),
            .ovf_o   (raw_ovf[g])
        );
        fsd_meas #(.W(SIG_W), .AVG_LOG2(AVG_LOG2)) u_sig (
            .clk_i   (clk24M),
            .rst_i   (rst),
            .din_i   (sig_in[g]),
            .res_o   (sig_res[g]),
            .valid_o (sig_valid[g]),
            .ovf_o   (sig_ovf[g])
        );
    end

    // Unmatched channel numbers fall through to all-zero.
    always_comb begin
        sel_data_d  = '0;
        sel_valid_d = 1'b0;
        sel_ovf_d   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == 3'(i)) begin
                sel_data_d  = rd_sel ? sig_res[i] : SIG_W'(raw_res[i]);
                sel_valid_d = rd_sel ? sig_valid[i] : raw_valid[i];
                sel_ovf_d   = rd_sel ? sig_ovf[i] : raw_ovf[i];
            end
        end
    end

    always_ff @(posedge clk24M or posedge rst) begin
        if (rst) begin
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_ovf_q   <= 1'b0;
        end else if (rd_ack_q) begin
            if (!rd_req) begin
                rd_ack_q <= 1'b0;
            end
        end else if (rd_req) begin
            rd_ack_q   <= 1'b1;
            rd_data_q  <= sel_data_d;
            rd_valid_q <= sel_valid_d;
            rd_ovf_q   <= sel_ovf_d;
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_ovf   = rd_ovf_q;
endmodule

// File: doc/fsd_core.md
FSD_CORE -- requirements
Module: fsd_core

Interface
REQ-001 Parameter NCH, default 3, number of channels (1..8).
REQ-002 Parameter LO_W, default 16, LO cycle register width.
REQ-003 Parameter RAW_W, default 16, raw (mixer) period result width.
REQ-004 Parameter SIG_W, default 24, signal period result width (SIG_W >= RAW_W).
REQ-005 Parameter AVG_LOG2, default 2, averaging window of 2^AVG_LOG2 periods (0..4).
REQ-006 Parameter LO_RST, default 100, LO cycle after reset.
REQ-007 Port clk24M input 1, sole clock (24 MHz).
REQ-008 Port rst input 1; reset is asynchronous and active-high.
REQ-009 Port mix_in input NCH, mixer signal inputs (asynchronous).
REQ-010 Port sig_in input NCH, signal inputs (asynchronous).
REQ-011 Port lo_out output NCH, local oscillator outputs.
REQ-012 Port mix_out output NCH, mixer outputs.
REQ-013 Port cfg_we input 1, LO cycle write strobe.
REQ-014 Port cfg_ch input 3, channel for cfg_we.
REQ-015 Port cfg_cycle input LO_W, new LO cycle.
REQ-016 Port rd_req input 1, read request (level).
REQ-017 Port rd_ch input 3, channel to read.
REQ-018 Port rd_sel input 1, 0 = raw result, 1 = signal result.
REQ-019 Port rd_ack output 1, read acknowledge.
REQ-020 Port rd_data output SIG_W, result (raw zero-extended).
REQ-021 Port rd_valid output 1, result valid since reset.
REQ-022 Port rd_ovf output 1, result saturated.

Function
REQ-023 Per channel, lo_cnt counts 0..cycle-1 then wraps; lo_out goes 1 when lo_cnt == cycle-1 and 0 when lo_cnt == (cycle>>1)-1, giving period = cycle clocks.
REQ-024 Cycle values 0 and 1 hold lo_out at 0 and lo_cnt at 0.
REQ-025 cfg_we with cfg_ch < NCH loads cfg_cycle and clears lo_cnt and lo_out on the next edge (phase restart); cfg_ch >= NCH is ignored.
REQ-026 mix_out = mix_in XOR lo_out, combinational.
REQ-027 Every mix_in/sig_in bit passes a 2-flop synchroniser, then a rising-edge detector; pin edge to detect pulse = 3 clocks.
REQ-028 Period P = clocks between consecutive detected rising edges; work counter loads 1 on an edge and increments otherwise, saturating at all-ones of its result width.
REQ-029 First edge after reset only arms the measurement; no period is accumulated.
REQ-030 Each period is added to a sum (width + AVG_LOG2 bits); after 2^AVG_LOG2 periods result = sum >> AVG_LOG2, valid set, sum cleared.
REQ-031 If the work counter saturated during any period of the window, result = all-ones and ovf = 1; otherwise ovf = 0.
REQ-032 Read: when rd_req = 1 and rd_ack = 0, on the next edge rd_data/rd_valid/rd_ovf latch the selected result and rd_ack = 1.
REQ-033 rd_ack holds 1 and outputs hold stable until rd_req = 0; rd_ack falls on the following edge.
REQ-034 rd_ch >= NCH returns rd_data = 0, rd_valid = 0, rd_ovf = 0, still acknowledged.
REQ-035 Result update in the same cycle as a read latch: the read returns the pre-update value.

Reset
REQ-036 rst asserts asynchronously: cycles = LO_RST, lo_cnt = 0, lo_out = 0, synchronisers/work/sum/results = 0, valid = 0, ovf = 0, armed = 0, rd_ack = 0, rd_data = 0, rd_valid = 0, rd_ovf = 0.
REQ-037 Reset mid-measurement or mid-handshake discards all partial state; operation restarts on the first edge after rst deasserts.

Verification
REQ-038 After reset, no writes -> lo_out on every channel period 100 clocks, high 50 clocks.
REQ-039 cfg_we, cfg_ch = 1, cfg_cycle = 0x0010 -> next cycle lo_out[1] = 0, then period 16 clocks; channels 0 and 2 unchanged; cfg_ch = 5 write changes nothing.
REQ-040 sig_in[0] square wave period 1000 clocks, AVG_LOG2 = 2 -> after 5 rising edges rd_sel = 1, rd_ch = 0 returns 1000, valid 1, ovf 0.
REQ-041 mix_in[2] held low after one edge for > 65535 clocks, then edges -> raw result 0xFFFF, rd_ovf = 1; next clean window clears ovf.
REQ-042 rd_req held 10 cycles -> rd_ack high one cycle after rise, data stable while high, falls one cycle after rd_req drops; rd_ch = 7 returns 0/0/0.
REQ-043 rst pulsed during an averaging window and during rd_ack = 1 -> all outputs immediately at reset values; first post-reset result requires arming edge plus full window.
